// File: rtl/cla_pkg.sv
// ---------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the serial carry-lookahead adder sequencer:
//   state_t   - sequencer state encoding (2'd3 is unused and recovers to IDLE)
//   NIBBLE_W  - width of one lookahead slice pass
//   width_ok  - elaboration-time legality check for the operand width
// ---------------------------------------------------------------------------
package cla_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int NIBBLE_W = 4;

   // Operand width must be a whole, non-zero number of nibbles.
   function automatic logic width_ok(input int w);
      return (w >= NIBBLE_W) && ((w % NIBBLE_W) == 0);
   endfunction

endpackage

// File: rtl/cla4_slice.sv
// ---------------------------------------------------------------------------
// cla4_slice
// Purely combinational 4-bit carry-lookahead adder slice.
// Ports:
//   x[3:0], y[3:0]  addend nibbles
//   ci              carry into bit 0
//   s[3:0]          nibble sum
//   co              carry out of bit 3
//   c3              carry into bit 3 (only when CLA_SERIAL_OVF_EN is defined)
// Every internal carry is a flat two-level sum of generate/propagate products,
// so no carry depends on another computed carry.
// ---------------------------------------------------------------------------
module cla4_slice (
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
`ifdef CLA_SERIAL_OVF_EN
   ,
   output logic       c3
`endif
);

   logic [3:0] g;
   logic [3:0] p;
   logic       c1;
   logic       c2;
   logic       c3_int;

   assign g = x & y;
   assign p = x ^ y;

   assign c1     = g[0] | (p[0] & ci);
   assign c2     = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
   assign c3_int = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & ci);
   assign co     = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

   assign s = p ^ {c3_int, c2, c1, ci};

`ifdef CLA_SERIAL_OVF_EN
   assign c3 = c3_int;
`endif

endmodule

// File: rtl/cla_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// cla_serial_add_ctrl
// Adds two WIDTH-bit operands plus carry-in by passing one nibble per cycle,
// LSB first, through a single shared 4-bit lookahead slice. A carry register
// links successive nibbles. Result appears NIBBLES cycles after acceptance
// and is held until the consumer takes it.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     operand handshake (a, b, cin)
//   out_valid/out_ready   result handshake (sum, cout[, ovf])
//   busy                  high whenever an operation is in flight or held
// Optional feature macro: CLA_SERIAL_OVF_EN adds output ovf, the signed
// two's-complement overflow of the full-width add.
// ---------------------------------------------------------------------------
module cla_serial_add_ctrl
   import cla_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
`ifdef CLA_SERIAL_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

   if (!width_ok(WIDTH)) begin : g_width_chk
      $error("cla_serial_add_ctrl: WIDTH must be a multiple of 4 and at least 4");
   end

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_q;
   logic             carry;
   logic             cout_q;
   logic             accept;
   logic [3:0]       x_nib;
   logic [3:0]       y_nib;
   logic [3:0]       s_nib;
   logic             co_s;
`ifdef CLA_SERIAL_OVF_EN
   logic             c3_s;
   logic             ovf_q;
`endif

   // Control: next state and handshake outputs
   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            in_ready = !rst;
            if (in_valid && !rst) state_nx = BUSY;
         end
         BUSY: begin
            if (cnt == LAST) state_nx = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            // A new in_valid here is ignored; input opens next cycle in IDLE.
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign accept = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Select the active nibble of each latched operand
   always_comb begin
      x_nib = '0;
      y_nib = '0;
      for (int i = 0; i < NIBBLES; i++) begin
         if (cnt == CNT_W'(i)) begin
            x_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
            y_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
         end
      end
   end

   cla4_slice u_slice (
      .x  (x_nib),
      .y  (y_nib),
      .ci (carry),
      .s  (s_nib),
      .co (co_s)
`ifdef CLA_SERIAL_OVF_EN
      ,
      .c3 (c3_s)
`endif
   );

   // Datapath: operand capture, per-nibble sum write-back, carry chain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         sum_q  <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         cout_q <= 1'b0;
`ifdef CLA_SERIAL_OVF_EN
         ovf_q  <= 1'b0;
`endif
      end else if (accept) begin
         a_q   <= a;
         b_q   <= b;
         carry <= cin;
         cnt   <= '0;
         sum_q <= '0;
      end else if (state == BUSY) begin
         for (int i = 0; i < NIBBLES; i++) begin
            if (cnt == CNT_W'(i)) sum_q[i*NIBBLE_W +: NIBBLE_W] <= s_nib;
         end
         carry <= co_s;
         if (cnt == LAST) begin
            cnt    <= '0;
            cout_q <= co_s;
`ifdef CLA_SERIAL_OVF_EN
            // Carry into the MSB differs from carry out of it -> signed overflow.
            ovf_q  <= c3_s ^ co_s;
`endif
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
`ifdef CLA_SERIAL_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cla_serial_add_ctrl
// Bench for cla_serial_add_ctrl with three instances: WIDTH=16 (directed and
// random), WIDTH=4 and WIDTH=32 (random). Expected results come from plain
// integer addition a+b+cin.
// ---------------------------------------------------------------------------
module tb_cla_serial_add_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic        iv[3];
   logic        ordy[3];
   logic        ic[3];
   logic [31:0] ia[3];
   logic [31:0] ib[3];

   logic        rdy16, ov16, co16, bs16;
   logic [15:0] s16;
   logic        rdy4, ov4, co4, bs4;
   logic [3:0]  s4;
   logic        rdy32, ov32, co32, bs32;
   logic [31:0] s32;
`ifdef CLA_SERIAL_OVF_EN
   logic        ovf16, ovf4, ovf32;
`endif

   cla_serial_add_ctrl #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(rdy16),
      .a(ia[0][15:0]), .b(ib[0][15:0]), .cin(ic[0]),
      .out_valid(ov16), .out_ready(ordy[0]), .sum(s16), .cout(co16), .busy(bs16)
`ifdef CLA_SERIAL_OVF_EN
      , .ovf(ovf16)
`endif
   );

   cla_serial_add_ctrl #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(rdy4),
      .a(ia[1][3:0]), .b(ib[1][3:0]), .cin(ic[1]),
      .out_valid(ov4), .out_ready(ordy[1]), .sum(s4), .cout(co4), .busy(bs4)
`ifdef CLA_SERIAL_OVF_EN
      , .ovf(ovf4)
`endif
   );

   cla_serial_add_ctrl #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(rdy32),
      .a(ia[2]), .b(ib[2]), .cin(ic[2]),
      .out_valid(ov32), .out_ready(ordy[2]), .sum(s32), .cout(co32), .busy(bs32)
`ifdef CLA_SERIAL_OVF_EN
      , .ovf(ovf32)
`endif
   );

   // Read the outputs of instance k in a width-independent form.
   task automatic get(input int k, output logic r, output logic v,
                      output logic co, output logic bs, output logic [31:0] s);
      case (k)
         0:       begin r = rdy16; v = ov16; co = co16; bs = bs16; s = {16'd0, s16}; end
         1:       begin r = rdy4;  v = ov4;  co = co4;  bs = bs4;  s = {28'd0, s4};  end
         default: begin r = rdy32; v = ov32; co = co32; bs = bs32; s = s32;          end
      endcase
   endtask

   // One complete operation on the 16-bit instance; called at posedge+1 in IDLE.
   task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic c,
                        output logic [15:0] s, output logic co, output logic ovo,
                        output int lat);
      ia[0] = {16'd0, a}; ib[0] = {16'd0, b}; ic[0] = c; iv[0] = 1'b1; ordy[0] = 1'b0;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      lat = 0;
      while (!ov16 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      s = s16; co = co16;
`ifdef CLA_SERIAL_OVF_EN
      ovo = ovf16;
`else
      ovo = 1'b0;
`endif
      ordy[0] = 1'b1;
      @(posedge clk); #1;
      ordy[0] = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (s16 !== 16'h0)  begin errors++; $display("FAIL reset_sum got=%h exp=0000", s16); end
      checks++; if (co16 !== 1'b0)  begin errors++; $display("FAIL reset_cout got=%b exp=0", co16); end
      checks++; if (ov16 !== 1'b0)  begin errors++; $display("FAIL reset_out_valid got=%b exp=0", ov16); end
      checks++; if (bs16 !== 1'b0)  begin errors++; $display("FAIL reset_busy got=%b exp=0", bs16); end
      @(negedge clk); rst = 1'b0; #1;
      checks++; if (rdy16 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", rdy16); end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      logic [15:0] av[3] = '{16'h1234, 16'hFFFF, 16'hFFFF};
      logic [15:0] bv[3] = '{16'h4321, 16'h0001, 16'h0000};
      logic        cv[3] = '{1'b0, 1'b0, 1'b1};
      logic [15:0] s; logic co, ovo; int lat;
      logic [16:0] e;
      for (int i = 0; i < 3; i++) begin
         run16(av[i], bv[i], cv[i], s, co, ovo, lat);
         e = {1'b0, av[i]} + {1'b0, bv[i]} + {16'd0, cv[i]};
         checks++; if (s !== e[15:0]) begin errors++; $display("FAIL basic_sum[%0d] got=%h exp=%h", i, s, e[15:0]); end
         checks++; if (co !== e[16])  begin errors++; $display("FAIL basic_cout[%0d] got=%b exp=%b", i, co, e[16]); end
         checks++; if (lat !== 4)     begin errors++; $display("FAIL basic_latency[%0d] got=%0d exp=4", i, lat); end
      end
   endtask

   task automatic test_backpressure();
      int lat;
      ia[0] = 32'h00F0; ib[0] = 32'h0010; ic[0] = 1'b0; iv[0] = 1'b1; ordy[0] = 1'b0;
      @(posedge clk); #1;
      // A second request (1+2) stays pending and must be ignored while busy.
      ia[0] = 32'h0001; ib[0] = 32'h0002;
      lat = 0;
      while (!ov16 && lat < 40) begin @(posedge clk); #1; lat++; end
      checks++; if (lat !== 4) begin errors++; $display("FAIL bp_latency got=%0d exp=4", lat); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (ov16 !== 1'b1)    begin errors++; $display("FAIL bp_out_valid[%0d] got=%b exp=1", i, ov16); end
         checks++; if (s16 !== 16'h0100) begin errors++; $display("FAIL bp_sum[%0d] got=%h exp=0100", i, s16); end
         checks++; if (co16 !== 1'b0)    begin errors++; $display("FAIL bp_cout[%0d] got=%b exp=0", i, co16); end
         checks++; if (rdy16 !== 1'b0)   begin errors++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, rdy16); end
         @(posedge clk); #1;
      end
      ordy[0] = 1'b1;
      @(posedge clk); #1;
      ordy[0] = 1'b0;
      checks++; if (ov16 !== 1'b0)  begin errors++; $display("FAIL bp_release_valid got=%b exp=0", ov16); end
      checks++; if (bs16 !== 1'b0)  begin errors++; $display("FAIL bp_release_busy got=%b exp=0", bs16); end
      checks++; if (rdy16 !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got=%b exp=1", rdy16); end
      @(posedge clk); #1;
      iv[0] = 1'b0;
      checks++; if (bs16 !== 1'b1)  begin errors++; $display("FAIL bp_next_accept got=%b exp=1", bs16); end
      lat = 0;
      while (!ov16 && lat < 40) begin @(posedge clk); #1; lat++; end
      checks++; if (s16 !== 16'h0003) begin errors++; $display("FAIL bp_next_sum got=%h exp=0003", s16); end
      ordy[0] = 1'b1;
      @(posedge clk); #1;
      ordy[0] = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [15:0] s; logic co, ovo; int lat;
      ia[0] = 32'hFFFF; ib[0] = 32'h0F0F; ic[0] = 1'b1; iv[0] = 1'b1;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1; #1;
      checks++; if (s16 !== 16'h0)  begin errors++; $display("FAIL rmid_sum got=%h exp=0000", s16); end
      checks++; if (co16 !== 1'b0)  begin errors++; $display("FAIL rmid_cout got=%b exp=0", co16); end
      checks++; if (ov16 !== 1'b0)  begin errors++; $display("FAIL rmid_out_valid got=%b exp=0", ov16); end
      checks++; if (bs16 !== 1'b0)  begin errors++; $display("FAIL rmid_busy got=%b exp=0", bs16); end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      run16(16'h0001, 16'h0001, 1'b0, s, co, ovo, lat);
      checks++; if (s !== 16'h0002) begin errors++; $display("FAIL rmid_fresh_sum got=%h exp=0002", s); end
      checks++; if (lat !== 4)      begin errors++; $display("FAIL rmid_fresh_latency got=%0d exp=4", lat); end
   endtask

`ifdef CLA_SERIAL_OVF_EN
   task automatic test_ovf();
      logic [15:0] s; logic co, ovo; int lat;
      run16(16'h7FFF, 16'h0001, 1'b0, s, co, ovo, lat);
      checks++; if (ovo !== 1'b1)   begin errors++; $display("FAIL ovf_pos got=%b exp=1", ovo); end
      checks++; if (s !== 16'h8000) begin errors++; $display("FAIL ovf_pos_sum got=%h exp=8000", s); end
      run16(16'h8000, 16'h8000, 1'b0, s, co, ovo, lat);
      checks++; if (ovo !== 1'b1)   begin errors++; $display("FAIL ovf_neg got=%b exp=1", ovo); end
      checks++; if (co !== 1'b1)    begin errors++; $display("FAIL ovf_neg_cout got=%b exp=1", co); end
      checks++; if (s !== 16'h0000) begin errors++; $display("FAIL ovf_neg_sum got=%h exp=0000", s); end
      run16(16'h1234, 16'h4321, 1'b0, s, co, ovo, lat);
      checks++; if (ovo !== 1'b0)   begin errors++; $display("FAIL ovf_none got=%b exp=0", ovo); end
   endtask
`endif

   // Random operands with random input gaps and output backpressure; every
   // accepted operation must produce exactly one matching result, in order.
   task automatic test_back_to_back(input int k, input int w);
      logic [63:0] exp_q[$];
      logic [63:0] mask;
      int          got_n;
      mask  = (64'd1 << w) - 64'd1;
      got_n = 0;
      fork
         begin : producer
            for (int n = 0; n < 200; n++) begin
               int   gap, g;
               logic acc, r, v, co, bs;
               logic [31:0] s;
               gap = $urandom_range(0, 2);
               repeat (gap) begin @(posedge clk); #1; end
               ia[k] = $urandom; ib[k] = $urandom; ic[k] = 1'($urandom_range(0, 1));
               iv[k] = 1'b1;
               acc = 1'b0; g = 0;
               while (!acc && g < 200) begin
                  get(k, r, v, co, bs, s);
                  acc = r;
                  @(posedge clk); #1;
                  g++;
               end
               iv[k] = 1'b0;
               if (acc) begin
                  exp_q.push_back(({32'd0, ia[k]} & mask) + ({32'd0, ib[k]} & mask) + {63'd0, ic[k]});
               end else begin
                  checks++; errors++;
                  $display("FAIL b2b_accept_timeout w=%0d op=%0d", w, n);
               end
            end
         end
         begin : consumer
            int cyc;
            cyc = 0;
            while (got_n < 200 && cyc < 20000) begin
               logic r, v, co, bs, hs;
               logic [31:0] s;
               logic [63:0] got, e;
               ordy[k] = 1'($urandom_range(0, 1));
               get(k, r, v, co, bs, s);
               hs  = v && ordy[k];
               got = ({63'd0, co} << w) | {32'd0, s};
               @(posedge clk); #1;
               cyc++;
               if (hs) begin
                  got_n++;
                  checks++;
                  if (exp_q.size() == 0) begin
                     errors++;
                     $display("FAIL b2b_extra_result w=%0d got=%h exp=none", w, got);
                  end else begin
                     e = exp_q.pop_front();
                     if (got !== e) begin
                        errors++;
                        $display("FAIL b2b_result w=%0d idx=%0d got=%h exp=%h", w, got_n, got, e);
                     end
                  end
               end
            end
            ordy[k] = 1'b0;
            checks++;
            if (got_n != 200) begin
               errors++;
               $display("FAIL b2b_result_count w=%0d got=%0d exp=200", w, got_n);
            end
         end
      join
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_dropped w=%0d got=%0d exp=0", w, exp_q.size());
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         iv[i] = 1'b0; ordy[i] = 1'b0; ic[i] = 1'b0; ia[i] = '0; ib[i] = '0;
      end
      test_reset();
      test_basic();
      test_backpressure();
      test_reset_mid();
`ifdef CLA_SERIAL_OVF_EN
      test_ovf();
`endif
      test_back_to_back(0, 16);
      test_back_to_back(1, 4);
      test_back_to_back(2, 32);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
